sequence_gen: RTL
=================

// Module: sequence_gen
// PURPOSE
//   Serial frame generator feeding the sequence detector: turns 6-bit words into a continuous
//   1-bit stream of back-to-back frames, MSB first, aligned to reset release. Idle frames carry
//   FILL. Reports frame boundaries, tags frames equal to PATTERN and keeps saturating counts,
//   so a bench checks detector match/not_match against generator-side ground truth.
// PARAMETERS
//   FRAME_W  6          bits per frame
//   PATTERN  6'b011100  target sequence; frames equal to it are tagged
//   FILL     6'b111111  frame sent when no word is pending (must differ from PATTERN)
//   CNT_W    16         width of frame_cnt / pat_cnt
// PORTS
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   wr_valid     in   1        word offered
//   wr_ready     out  1        hold slot free or being emptied this cycle (combinational)
//   wr_data      in   FRAME_W  word to send, bit FRAME_W-1 first
//   wr_use_pat   in   1        1: send PATTERN instead of wr_data
//   clr_cnt      in   1        synchronous clear of both counters
//   data         out  1        serial stream (registered)
//   frame_start  out  1        data is bit 0 (MSB) of a frame
//   frame_last   out  1        data is last bit of a frame
//   frame_pat    out  1        frame_last & current frame == PATTERN
//   frame_cnt    out  CNT_W    completed frames, saturating
//   pat_cnt      out  CNT_W    completed PATTERN frames, saturating
// BEHAVIOUR
//   - State: shreg[FRAME_W-1:0], bit counter cnt 0..FRAME_W-1, one-entry hold (hold_v, hold_w),
//     cur_pat flag. data = shreg[FRAME_W-1]; frame_start = (cnt==0); frame_last = (cnt==FRAME_W-1).
//   - Reset: shreg=FILL, cnt=0, hold_v=0, cur_pat=0, counters=0. So data=FILL[5]=1,
//     frame_start=1, frame_last=0, frame_pat=0, wr_ready=1 while reset is asserted; the first
//     clock after release sends frame 0 bit 0, matching detector alignment.
//   - Stream FSM per clock: cnt<FRAME_W-1 -> shreg<<=1, cnt++. cnt==FRAME_W-1 (boundary) ->
//     cnt=0, shreg = hold_v ? hold_w : FILL, cur_pat = (loaded word == PATTERN), hold_v cleared
//     if consumed. Stream never stalls; gaps are filled with FILL frames.
//   - Handshake: accept = wr_valid & wr_ready; wr_ready = !hold_v | (cnt==FRAME_W-1).
//     Accepted word stored = wr_use_pat ? PATTERN : wr_data. Accept on a boundary with hold
//     empty: word goes to hold, this boundary loads FILL (no bypass). Accept on a boundary with
//     hold full: old hold -> shreg, new word -> hold in the same edge. Inputs ignored when !ready.
//   - Latency: word accepted at bit index k starts on data FRAME_W-k cycles later if hold was
//     empty (k<5); at boundary acceptance, 1+FRAME_W cycles later.
//   - A wr_data value equal to PATTERN is tagged identically to wr_use_pat=1.
//   - Counters update on boundary cycles: frame_cnt+1; pat_cnt+1 if cur_pat. Both saturate at
//     all-ones. clr_cnt has priority: counters -> 0 that cycle, increment of that cycle dropped.
//   - Reset mid-frame: partial frame abandoned, hold discarded, stream restarts at FILL frame 0.
// TESTING
//   1 Reset, no writes, 18 cycles -> data 111111x3, frame_start at cycles 0/6/12, frame_cnt=3,
//     pat_cnt=0, frame_pat never set.
//   2 Write wr_use_pat=1 at cnt=2 -> next frame data 0,1,1,1,0,0, frame_pat on its 6th bit,
//     pat_cnt=1; wired detector pulses match one cycle after that frame_last.
//   3 Write wr_data=6'b011100 then 6'b010101 back-to-back from cnt=0 -> second write waits
//     until boundary (wr_ready=0 at cnt 1..4, 1 at cnt 5); frames sent in order, pat_cnt=1.
//   4 Write held valid continuously for 10 frames -> no FILL frames after the first,
//     exactly one accept per frame, frame_cnt increments every 6 cycles.
//   5 Preload frame_cnt to all-ones-1 (run), then 2 frames -> saturates at all-ones;
//     clr_cnt on a boundary cycle -> both counters read 0 next cycle.
//   6 Assert rst_n low at cnt=3 with hold full -> outputs at reset values immediately,
//     after release stream is FILL frame aligned to cnt=0, held word never sent.

Source files
------------

// File: rtl/sequence_gen.sv
// Serial frame generator: 6-bit words become back-to-back MSB-first frames with FILL frames in
// the gaps; frame boundaries are flagged, PATTERN frames are tagged and saturating counts are kept.
module sequence_gen #(
  parameter int unsigned          FRAME_W = 6,
  parameter logic [FRAME_W-1:0]   PATTERN = 6'b011100,
  parameter logic [FRAME_W-1:0]   FILL    = 6'b111111,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               wr_use_pat,
  input  logic               clr_cnt,
  output logic               data,
  output logic               frame_start,
  output logic               frame_last,
  output logic               frame_pat,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   pat_cnt
);

  localparam int unsigned  CW   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hold_v_q, hold_v_d;
  logic [FRAME_W-1:0] hold_w_q, hold_w_d;
  logic               cur_pat_q, cur_pat_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   pat_cnt_q, pat_cnt_d;

  logic               boundary;
  logic               accept;
  logic [FRAME_W-1:0] acc_word;
  logic [FRAME_W-1:0] load_word;

  always_comb begin
    boundary  = (cnt_q == LAST);
    wr_ready  = !hold_v_q || boundary;
    accept    = wr_valid && wr_ready;
    acc_word  = wr_use_pat ? PATTERN : wr_data;
    load_word = hold_v_q ? hold_w_q : FILL;

    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_v_d    = hold_v_q;
    hold_w_d    = hold_w_q;
    cur_pat_d   = cur_pat_q;
    frame_cnt_d = frame_cnt_q;
    pat_cnt_d   = pat_cnt_q;

    if (boundary) begin
      cnt_d     = '0;
      shreg_d   = load_word;
      cur_pat_d = (load_word == PATTERN);
      hold_v_d  = 1'b0;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
    end

    // Applied after the boundary load so a boundary accept refills the slot just emptied.
    if (accept) begin
      hold_v_d = 1'b1;
      hold_w_d = acc_word;
    end

    if (clr_cnt) begin
      frame_cnt_d = '0;
      pat_cnt_d   = '0;
    end else if (boundary) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
      if (cur_pat_q && (pat_cnt_q != '1)) pat_cnt_d = pat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= FILL;
      cnt_q       <= '0;
      hold_v_q    <= 1'b0;
      hold_w_q    <= '0;
      cur_pat_q   <= 1'b0;
      frame_cnt_q <= '0;
      pat_cnt_q   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_v_q    <= hold_v_d;
      hold_w_q    <= hold_w_d;
      cur_pat_q   <= cur_pat_d;
      frame_cnt_q <= frame_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
    end
  end

  assign data        = shreg_q[FRAME_W-1];
  assign frame_start = (cnt_q == '0);
  assign frame_last  = boundary;
  assign frame_pat   = boundary && cur_pat_q;
  assign frame_cnt   = frame_cnt_q;
  assign pat_cnt     = pat_cnt_q;

endmodule
